pcf8591_dac_writer: RTL and testbench

- I2C write engine for the PCF8591 DAC. It sits directly downstream of the board's I2C bit-rate divider and consumes its timing role as an internal quarter-bit clock enable, so the whole design runs on one clock with no derived clock.
- On each start request it issues one complete bus transaction: START, address byte, control byte, DAC data byte, STOP.
- Drives SCL push-pull and SDA open-drain via an output enable. Reports busy, done and ACK error to the application logic.

---
 rtl/pcf8591_dac_writer_if.sv | 34 +++
 rtl/pcf8591_dac_writer.sv | 179 +++++++++++++++++
 tb/tb_pcf8591_dac_writer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pcf8591_dac_writer_if.sv
// Application-side handshake and I2C pin bundle for the PCF8591 DAC write engine.
// The engine uses the slave modport; whoever drives requests and the SDA pin uses master.
interface pcf8591_dac_writer_if;
    logic       start;
    logic [7:0] dac_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    logic       sda_oe;
    logic       sda_i;

    modport master (
        output start,
        output dac_data,
        output sda_i,
        input  busy,
        input  done,
        input  ack_err,
        input  scl,
        input  sda_oe
    );

    modport slave (
        input  start,
        input  dac_data,
        input  sda_i,
        output busy,
        output done,
        output ack_err,
        output scl,
        output sda_oe
    );
endinterface

// File: rtl/pcf8591_dac_writer.sv
// I2C write engine for the PCF8591 DAC: START, address, control, data byte, STOP.
// Runs on one clock; a quarter-bit enable derived from QDIV paces the bus.
module pcf8591_dac_writer #(
    parameter int unsigned QDIV      = 30,
    parameter logic [6:0]  DEV_ADDR  = 7'h48,
    parameter logic [7:0]  CTRL_BYTE = 8'h40
) (
    input logic                 clk,
    input logic                 rst,
    pcf8591_dac_writer_if.slave bus
);

    localparam int unsigned     CntW    = (QDIV > 2) ? $clog2(QDIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(QDIV - 1);
    localparam logic [7:0]      AddrWr  = {DEV_ADDR, 1'b0};

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StByte,
        StAck,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [7:0]      data_q, data_d;
    logic            ack_err_q, ack_err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;

    logic            tick;
    logic [7:0]      cur_byte;

    assign tick = (cnt_q == CntLast);

    // Next-state sequencing; the quarter counter only advances outside IDLE and DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        data_d    = data_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StStart;
                    cnt_d     = '0;
                    qtr_d     = 2'd0;
                    bit_d     = 3'd7;
                    byte_d    = 2'd0;
                    data_d    = bus.dac_data;
                    ack_err_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                cnt_d = tick ? '0 : cnt_q + CntW'(1);
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    // Slave ACK is sampled at the end of the SCL-high q2 of the ninth bit.
                    if (state_q == StAck && qtr_q == 2'd2 && bus.sda_i) begin
                        ack_err_d = 1'b1;
                    end
                    if (qtr_q == 2'd3) begin
                        case (state_q)
                            StStart: begin
                                state_d = StByte;
                                bit_d   = 3'd7;
                            end
                            StByte: begin
                                if (bit_q == 3'd0) begin
                                    state_d = StAck;
                                end else begin
                                    bit_d = bit_q - 3'd1;
                                end
                            end
                            StAck: begin
                                if (ack_err_q || byte_q == 2'd2) begin
                                    state_d = StStop;
                                end else begin
                                    state_d = StByte;
                                    byte_d  = byte_q + 2'd1;
                                    bit_d   = 3'd7;
                                end
                            end
                            StStop: begin
                                state_d = StDone;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        unique case (byte_d)
            2'd0:    cur_byte = AddrWr;
            2'd1:    cur_byte = CTRL_BYTE;
            default: cur_byte = data_d;
        endcase
    end

    // Pin levels are decoded from the next state so scl/sda_oe come straight from flops.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        unique case (state_d)
            StStart: begin
                sda_oe_d = qtr_d[1];
            end
            StByte: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~cur_byte[bit_d];
            end
            StAck: begin
                scl_d = qtr_d[1];
            end
            StStop: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd7;
            byte_q    <= 2'd0;
            data_q    <= 8'h00;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            data_q    <= data_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ack_err = ack_err_q;
    assign bus.scl     = scl_q;
    assign bus.sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_pcf8591_dac_writer.sv
// Directed bench for pcf8591_dac_writer: a small I2C slave model decodes the bus
// and ACKs per a mask; a second instance runs at QDIV=2 for back-to-back starts.
module tb_pcf8591_dac_writer;

    logic clk;
    logic rst;
    int   cyc;
    int   n_total;
    int   n_bad;

    pcf8591_dac_writer_if b1 ();
    pcf8591_dac_writer_if b2 ();

    pcf8591_dac_writer #(.QDIV(30)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    pcf8591_dac_writer #(.QDIV(2)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model on the QDIV=30 instance.
    logic [3:0] ack_mask;
    logic       slave_pull;
    logic       sda_line;
    logic       prev_scl;
    logic       prev_sda;
    logic [3:0] bitcnt;
    logic [2:0] nbytes;
    logic [7:0] shreg;
    logic [7:0] got_bytes [0:3];
    int         start_cnt;
    int         stop_cnt;
    int         last_rise;
    int         scl_period;

    assign sda_line = ~(b1.sda_oe | slave_pull);
    assign b1.sda_i = sda_line;
    assign b2.sda_i = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            slave_pull <= 1'b0;
            prev_scl   <= 1'b1;
            prev_sda   <= 1'b1;
            bitcnt     <= 4'd0;
            nbytes     <= 3'd0;
            shreg      <= 8'h00;
            start_cnt  <= 0;
            stop_cnt   <= 0;
            last_rise  <= 0;
            scl_period <= 0;
        end else begin
            prev_scl <= b1.scl;
            prev_sda <= sda_line;
            if (prev_scl && b1.scl && prev_sda && !sda_line) begin
                start_cnt <= start_cnt + 1;
                bitcnt    <= 4'd0;
                nbytes    <= 3'd0;
            end
            if (prev_scl && b1.scl && !prev_sda && sda_line) stop_cnt <= stop_cnt + 1;
            if (!prev_scl && b1.scl) begin
                last_rise <= cyc;
                if (bitcnt < 4'd8) begin
                    shreg <= {shreg[6:0], sda_line};
                    if (bitcnt == 4'd7) got_bytes[nbytes[1:0]] <= {shreg[6:0], sda_line};
                    if (nbytes == 3'd0 && bitcnt == 4'd1) scl_period <= cyc - last_rise;
                    bitcnt <= bitcnt + 4'd1;
                end else begin
                    bitcnt <= 4'd0;
                    nbytes <= nbytes + 3'd1;
                end
            end
            if (prev_scl && !b1.scl) slave_pull <= (bitcnt == 4'd8) && ack_mask[nbytes[1:0]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One transaction on the slow instance; poke adds ignored starts at cycle 500 and in DONE.
    task automatic run_txn(input string tag, input logic [7:0] d, input int exp_lat,
                           input logic exp_err, input bit poke);
        int t0;
        int n;
        int lat;
        int busy_bad;
        int s0;
        int p0;
        int extra;
        lat      = -1;
        busy_bad = 0;
        s0       = start_cnt;
        p0       = stop_cnt;
        @(negedge clk);
        b1.start    = 1'b1;
        b1.dac_data = d;
        t0          = cyc;
        @(negedge clk);
        b1.start = 1'b0;
        check_eq({tag, "_errclr"}, b1.ack_err, 1'b0);
        for (int i = 0; i < 4000 && lat < 0; i++) begin
            n = cyc - t0;
            if (b1.done) lat = n;
            else if (!b1.busy) busy_bad++;
            if (poke && n == 500) begin
                b1.start    = 1'b1;
                b1.dac_data = 8'h3C;
            end else if (poke && n == 501) begin
                b1.start = 1'b0;
            end
            if (lat < 0) @(negedge clk);
        end
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_busy_done"}, b1.busy, 1'b0);
        check_eq({tag, "_busy_hi"}, busy_bad, 0);
        check_eq({tag, "_ackerr"}, b1.ack_err, exp_err);
        check_eq({tag, "_starts"}, start_cnt - s0, 1);
        check_eq({tag, "_stops"}, stop_cnt - p0, 1);
        if (poke) begin
            b1.start    = 1'b1;
            b1.dac_data = 8'h3C;
            @(negedge clk);
            b1.start = 1'b0;
            check_eq({tag, "_poke_idle"}, b1.busy, 1'b0);
            extra = 0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (b1.done || b1.busy) extra++;
            end
            check_eq({tag, "_poke_extra"}, extra, 0);
        end
    endtask

    task automatic wait_fast_done(input string tag, input int t0);
        int lat;
        lat = -1;
        for (int i = 0; i < 400 && lat < 0; i++) begin
            if (b2.done) lat = cyc - t0;
            else @(negedge clk);
        end
        check_eq({tag, "_lat"}, lat, 233);
    endtask

    initial begin
        int t0;
        n_total     = 0;
        n_bad       = 0;
        cyc         = 0;
        rst         = 1'b1;
        ack_mask    = 4'b0111;
        b1.start    = 1'b0;
        b1.dac_data = 8'h00;
        b2.start    = 1'b0;
        b2.dac_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_scl", b1.scl, 1'b1);
        check_eq("rst_oe", b1.sda_oe, 1'b0);
        check_eq("rst_busy", b1.busy, 1'b0);
        check_eq("rst_done", b1.done, 1'b0);
        check_eq("rst_err", b1.ack_err, 1'b0);

        // Normal write
        run_txn("norm", 8'hA5, 3481, 1'b0, 1'b0);
        check_eq("norm_nb", nbytes, 3);
        check_eq("norm_b0", got_bytes[0], 8'h90);
        check_eq("norm_b1", got_bytes[1], 8'h40);
        check_eq("norm_b2", got_bytes[2], 8'hA5);
        check_eq("norm_period", scl_period, 120);

        // Ignored starts mid-transaction and in the done cycle
        run_txn("poke", 8'hA5, 3481, 1'b0, 1'b1);
        check_eq("poke_b2", got_bytes[2], 8'hA5);

        // Address NACK
        ack_mask = 4'b0000;
        run_txn("anack", 8'hA5, 1321, 1'b1, 1'b0);
        check_eq("anack_nb", nbytes, 1);
        check_eq("anack_b0", got_bytes[0], 8'h90);
        repeat (50) @(negedge clk);
        check_eq("anack_hold", b1.ack_err, 1'b1);

        // Data-byte NACK
        ack_mask = 4'b0011;
        run_txn("dnack", 8'hA5, 3481, 1'b1, 1'b0);
        check_eq("dnack_nb", nbytes, 3);
        check_eq("dnack_b2", got_bytes[2], 8'hA5);

        // Reset in the middle of the address byte
        ack_mask = 4'b0111;
        @(negedge clk);
        b1.start    = 1'b1;
        b1.dac_data = 8'hA5;
        t0          = cyc;
        @(negedge clk);
        b1.start = 1'b0;
        while (cyc - t0 < 1000) @(negedge clk);
        check_eq("mid_busy", b1.busy, 1'b1);
        check_eq("mid_scl_low", b1.scl, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mrst_scl", b1.scl, 1'b1);
        check_eq("mrst_oe", b1.sda_oe, 1'b0);
        check_eq("mrst_busy", b1.busy, 1'b0);
        check_eq("mrst_err", b1.ack_err, 1'b0);
        repeat (5) @(negedge clk);
        run_txn("after", 8'h3C, 3481, 1'b0, 1'b0);
        check_eq("after_b0", got_bytes[0], 8'h90);
        check_eq("after_b1", got_bytes[1], 8'h40);
        check_eq("after_b2", got_bytes[2], 8'h3C);

        // QDIV=2, second start in the cycle right after done
        @(negedge clk);
        b2.start    = 1'b1;
        b2.dac_data = 8'h5A;
        t0          = cyc;
        @(negedge clk);
        b2.start = 1'b0;
        check_eq("fast1_busy", b2.busy, 1'b1);
        wait_fast_done("fast1", t0);
        @(negedge clk);
        b2.start    = 1'b1;
        b2.dac_data = 8'hC3;
        t0          = cyc;
        @(negedge clk);
        b2.start = 1'b0;
        check_eq("fast2_busy", b2.busy, 1'b1);
        wait_fast_done("fast2", t0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
